// File: rtl/spi_master_frame.sv
// Command-driven SPI frame initiator: serialises {cmd_type, cmd_data} MSB-first, and on read-data frames collects an 8-bit reply.
// Define SPI_MASTER_FRAME_ASSERT_EN to compile in protocol assertions and covers.
module spi_master_frame #(
    parameter int RD_GAP = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_type_i,
    input  logic [7:0] cmd_data_i,
    output logic       ss_n_o,
    output logic       mosi_o,
    input  logic       miso_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        WAIT_RD,
        RECV,
        STOP
    } state_e;

    localparam logic [3:0] GAP_LAST = 4'(RD_GAP - 1);

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [9:0] tx_q;
    logic [7:0] rx_q;
    logic [7:0] rx_d;
    logic       rd_q;
    logic       ss_n_q;
    logic       mosi_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;

    assign rx_d = {rx_q[6:0], miso_i};

    // Outputs are registered, so each one is loaded on the edge entering the state that shows it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rd_q        <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ss_n_q      <= 1'b1;
                    mosi_q      <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    if (cmd_valid_i) begin
                        tx_q    <= {cmd_type_i, cmd_data_i};
                        rd_q    <= &cmd_type_i;
                        ss_n_q  <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    mosi_q  <= tx_q[9];
                    tx_q    <= {tx_q[8:0], 1'b0};
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (cnt_q == 4'd9) begin
                        mosi_q <= 1'b0;
                        cnt_q  <= '0;
                        if (rd_q && (RD_GAP > 0)) begin
                            state_q <= WAIT_RD;
                        end else if (rd_q) begin
                            state_q <= RECV;
                        end else begin
                            ss_n_q  <= 1'b1;
                            state_q <= STOP;
                        end
                    end else begin
                        mosi_q <= tx_q[9];
                        tx_q   <= {tx_q[8:0], 1'b0};
                        cnt_q  <= cnt_q + 4'd1;
                    end
                end
                WAIT_RD: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= RECV;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RECV: begin
                    rx_q <= rx_d;
                    if (cnt_q == 4'd7) begin
                        ss_n_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rx_d;
                        cnt_q       <= '0;
                        state_q     <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                STOP: begin
                    ss_n_q      <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign ss_n_o      = ss_n_q;
    assign mosi_o      = mosi_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;

`ifdef SPI_MASTER_FRAME_ASSERT_EN
    logic [5:0] lo_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || ss_n_o) lo_cnt_q <= '0;
        else                 lo_cnt_q <= lo_cnt_q + 6'd1;
    end

    a_ss_fall: assert property (@(posedge clk_i) disable iff (rst_i)
        $fell(ss_n_o) |-> $past(cmd_valid_i && cmd_ready_o));

    // lo_cnt_q still holds the completed low-time during the STOP cycle.
    a_ss_len: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == STOP) |-> (int'(lo_cnt_q) == (rd_q ? 19 + RD_GAP : 11)));

    a_rsp_stop: assert property (@(posedge clk_i) disable iff (rst_i)
        rsp_valid_o |-> (state_q == STOP && rd_q));

    a_ready_sel: assert property (@(posedge clk_i) disable iff (rst_i)
        cmd_ready_o |-> ss_n_o);

    c_rsp: cover property (@(posedge clk_i) disable iff (rst_i) rsp_valid_o);
    c_wait: cover property (@(posedge clk_i) disable iff (rst_i) state_q == WAIT_RD);
`endif

endmodule

// File: doc/spi_master_frame.md
# spi_master_frame

Command-driven SPI frame initiator that drives the SPI slave/RAM subsystem from the host side. It accepts one 10-bit command word per handshake and serialises it MSB-first on `mosi` under `ss_n`. For read-data commands (`cmd_type` = 2'b11) it keeps `ss_n` asserted, waits a fixed gap, and deserialises the 8-bit reply from `miso` onto a response port. It sits in the testbench/host layer and is the initiating end of the slave's serial protocol.

## Interface
- `RD_GAP`, default 2: idle cycles between the last command bit and the first sampled `miso` bit on read-data frames; legal range 0..15.
- `clk` input 1: single clock; `mosi`, `ss_n` and `miso` are all synchronous to it.
- `rst` input 1: reset, synchronous and active-high.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: block can accept a command; equals (state == IDLE).
- `cmd_type` input 2: frame type, which becomes frame bits [9:8]:
  - 00 write address
  - 01 write data
  - 10 read address
  - 11 read data
- `cmd_data` input 8: frame bits [7:0].
- `ss_n` output 1: slave select, active-low.
- `mosi` output 1: serial data to the slave.
- `miso` input 1: serial data from the slave.
- `rsp_valid` output 1: one-cycle pulse, read data available.
- `rsp_data` output 8: last received read byte; held until the next read completes.
- `busy` output 1: high in every state except IDLE.

## Operation
- The FSM has six states: IDLE, START, SHIFT, WAIT_RD, RECV, STOP.
- A 4-bit counter and a 10-bit TX shift register hold `{cmd_type, cmd_data}`; an 8-bit RX shift register collects the reply.
- **IDLE:**
  - `ss_n`=1, `mosi`=0.
  - When `cmd_valid` && `cmd_ready`: latch the word, go to START.
- **START:** one cycle; `ss_n`=0, `mosi`=0.
- **SHIFT:** 10 cycles; `mosi` = word[9] down to word[0], then:
  - `cmd_type`==11 with RD_GAP>0 → WAIT_RD.
  - `cmd_type`==11 with RD_GAP==0 → RECV.
  - Any other `cmd_type` → STOP.
- **WAIT_RD:** RD_GAP cycles; `ss_n`=0, `mosi`=0.
- **RECV:** 8 cycles; `mosi`=0; on each clock edge `rx_sh` <= {`rx_sh`[6:0], `miso`}, so the byte arrives MSB first.
- **STOP:** one cycle.
  - `ss_n`=1.
  - On read-data frames: `rsp_valid`=1 and `rsp_data`=`rx_sh`.
  - Then go to IDLE.
- All outputs are registered except `cmd_ready` and `busy`, which are decoded from the state.
- `cmd_valid` is ignored outside IDLE. Commands are not queued.
- Reset values: `ss_n`=1, `mosi`=0, `rsp_valid`=0, `rsp_data`=8'h00, state=IDLE, counter=0. As a result `cmd_ready`=1 and `busy`=0 from the first cycle after reset.
- Reset asserted mid-frame:
  - Next edge: IDLE with `ss_n`=1.
  - The partial frame is abandoned and no `rsp_valid` is produced.
  - `rsp_data` is cleared.

## Timing
- Handshake accepted at edge T. START occupies T+1, and the SHIFT bits appear on T+2..T+11.
- Write or read-address frame:
  - STOP at T+12; IDLE and `cmd_ready`=1 at T+13.
  - `ss_n` is low for exactly 11 cycles.
- Read-data frame:
  - WAIT_RD on T+12..T+11+RD_GAP.
  - RECV on T+12+RD_GAP..T+19+RD_GAP.
  - STOP and `rsp_valid` at T+20+RD_GAP.
  - `ss_n` is low for 19+RD_GAP cycles.
- Back-to-back commands leave at least one STOP cycle plus one IDLE cycle with `ss_n`=1 between frames.
- `cmd_valid` arriving in the STOP cycle is not accepted until the following IDLE cycle.

## Configuration
- With `SPI_MASTER_FRAME_ASSERT_EN` defined, concurrent assertions and covers are compiled in, each disabled while `rst` is high:
  - `ss_n` falls only on the cycle after an accepted handshake.
  - `ss_n` low-time is 11 cycles for non-read-data frames and 19+RD_GAP for read-data frames.
  - `rsp_valid` is asserted only in STOP of an 11-type frame.
  - `cmd_ready` and `ss_n` are never both 0.
- Without the macro, the RTL contains no assertion code. Functional behaviour is identical either way.

## Test plan
- Reset, then idle for 5 cycles → `ss_n`=1, `mosi`=0, `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_data`=00 throughout.
- Write-address command `cmd_type`=00, `cmd_data`=8'hA5:
  - `mosi` sequence 0,0,1,0,1,0,0,1,0,1 on T+2..T+11.
  - `ss_n` low for 11 cycles; no `rsp_valid`.
- Read address 10/8'h3C, then read data 11/8'h00, with RD_GAP=2 and a slave model returning 8'hC3:
  - `rsp_valid` for one cycle at T+22 of the second frame, `rsp_data`=C3.
  - Second frame has `ss_n` low for 21 cycles.
- Keep `cmd_valid` held high for 3 commands:
  - Each frame is separated by `ss_n`=1 for 2 cycles.
  - Commands are accepted only in IDLE; exactly 3 frames are sent.
- Assert `rst` at the 5th RECV cycle of a read-data frame → next edge `ss_n`=1, state IDLE, `rsp_data`=00, no `rsp_valid` pulse.
- RD_GAP=0 build:
  - Read-data `miso` bits are sampled on T+12..T+19 and `rsp_valid` occurs at T+20.
  - With `SPI_MASTER_FRAME_ASSERT_EN` defined, no assertion fires.
